serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial two's-complement subtractor: it computes A − B − Bin over W clock cycles, one bit per cycle, LSB first. A single full-subtractor cell and a registered borrow replace the W-cell ripple chain. It is the subtraction counterpart to the team's half/full-adder arithmetic blocks and is meant for area-constrained datapaths that can accept W-cycle latency. It provides a start/busy/done handshake, a serial output stream and a parallel result register.

## Interface
- W, default 8, operand and result width in bits (W ≥ 2).
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a subtraction; sampled only in IDLE or DONE.
- a  input  W  minuend; captured on an accepted start.
- b  input  W  subtrahend; captured on an accepted start.
- bin  input  1  borrow-in; captured on an accepted start.
- busy  output  1  high while in RUN.
- dout_bit  output  1  current difference bit; meaningful only while dout_valid is high.
- dout_valid  output  1  high during each of the W RUN cycles.
- done  output  1  one-cycle pulse in DONE.
- diff  output  W  parallel difference; held from DONE until the next accepted start.
- bout  output  1  final borrow-out; held with diff.

## Operation
- State machine has three states: IDLE, RUN and DONE.
- **IDLE**
  - start=1: load shift registers sa←a and sb←b, load the borrow register br←bin, clear the bit counter cnt←0, then go to RUN.
  - start=0: stay in IDLE.
- **RUN** (one bit per cycle, i = cnt)
  - Difference bit: d = sa[0] ^ sb[0] ^ br.
  - Borrow: br_next = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br).
  - dout_bit = d.
  - diff shifts right with d entering at bit W−1. After W shifts, diff[j] holds bit j of the result.
  - sa and sb shift right by one.
  - cnt increments by one.
  - When cnt = W−1, go to DONE.
- **DONE**
  - done=1 and bout=br.
  - start=1: accept exactly as in IDLE and go directly to RUN (back-to-back operation).
  - start=0: go to IDLE.
- start in RUN is ignored; no queuing.
- diff and bout are not cleared on start. They change only during the next RUN/DONE.
- Arithmetic is modulo 2^W. bout=1 exactly when a < b + bin as unsigned values.
- cnt width is clog2(W). cnt never exceeds W−1.

## Timing
- Reset (asynchronous, rst_n=0) immediately forces:
  - state to IDLE;
  - busy=0, done=0, dout_valid=0, dout_bit=0;
  - diff=0 and bout=0;
  - internal sa, sb, br and cnt to 0.
- Reset mid-RUN aborts the operation. No done is produced, and the partial result is lost.
- Cycle-by-cycle sequence, with start sampled high at rising edge E0:
  - Cycles E0..E0+W−1 are RUN: busy=1 and dout_valid=1. Bit i is presented during cycle E0+i.
  - Cycle E0+W is DONE: done=1, busy=0, and diff/bout are final.
  - Latency from the accepted start edge to done high is W cycles.
- Throughput with back-to-back starts is one result per W+1 cycles.
- Outputs are decoded directly from registered state with no input-to-output combinational path. dout_bit is a function of registered sa, sb and br only.

## Test plan
- **Basic subtraction:** W=8, a=0x05, b=0x03, bin=0, start pulse → serial bits 0,1,0,0,0,0,0,0; then done with diff=0x02, bout=0.
- **Negative result:** a=0x03, b=0x05, bin=0 → diff=0xFE, bout=1.
- **Borrow-in and zero operands:** a=0x00, b=0x00, bin=1 → diff=0xFF, bout=1. a=0xFF, b=0x01, bin=0 → diff=0xFE, bout=0.
- **Start during RUN:** start during RUN with a=0x10 and b=0x01, issued mid-operation → ignored. The current result completes unchanged, and busy stays high for exactly W cycles.
- **Back-to-back:** start held high in DONE with new operands 0x80 and 0x01 → RUN re-entered the next cycle. Final diff=0x7F, bout=0. done pulses once per operation.
- **Reset mid-RUN:** rst_n pulsed low at RUN cycle 3 → all outputs 0 immediately. IDLE after release, no done. A following 0x0A−0x0A produces diff=0x00, bout=0.

Source files
------------

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial two's-complement subtractor, one difference bit per clock, LSB first
module serial_subtractor #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic         busy,
  output logic         dout_bit,
  output logic         dout_valid,
  output logic         done,
  output logic [W-1:0] diff,
  output logic         bout
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  state_t         state_next;
  logic [W-1:0]   sa;
  logic [W-1:0]   sb;
  logic           br;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   diff_r;
  logic           bout_r;
  logic           accept;
  logic           last;
  logic           d;
  logic           br_next;

  // Full-subtractor cell shared by every bit position.
  assign d       = sa[0] ^ sb[0] ^ br;
  assign br_next = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
  assign last    = (cnt == CW'(W - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    busy       = 1'b0;
    dout_valid = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        busy       = 1'b1;
        dout_valid = 1'b1;
        if (last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Gated so the stale final borrow left in br does not leak out after RUN.
  assign dout_bit = dout_valid & d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa     <= '0;
      sb     <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      diff_r <= '0;
      bout_r <= 1'b0;
    end else if (accept) begin
      sa  <= a;
      sb  <= b;
      br  <= bin;
      cnt <= '0;
    end else if (state == RUN) begin
      sa     <= sa >> 1;
      sb     <= sb >> 1;
      br     <= br_next;
      diff_r <= {d, diff_r[W-1:1]};
      if (last) begin
        bout_r <= br_next;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign diff = diff_r;
  assign bout = bout_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - scoreboard bench for serial_subtractor with randomized operands
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         dout_bit;
  logic         dout_valid;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;

  serial_subtractor #(.W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .bin        (bin),
    .busy       (busy),
    .dout_bit   (dout_bit),
    .dout_valid (dout_valid),
    .done       (done),
    .diff       (diff),
    .bout       (bout)
  );

  typedef struct packed {
    logic [W-1:0] d;
    logic         bo;
  } exp_t;

  exp_t q[$];
  int   n_cmp    = 0;
  int   n_fail   = 0;
  int   n_pushed = 0;
  int   n_done   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain unsigned arithmetic, result modulo 2^W, borrow when a < b + bin.
  function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin);
    exp_t e;
    int unsigned ua, ub;
    ua   = ta;
    ub   = tb + tbin;
    e.d  = W'((ua + (1 << W) - ub) % (1 << W));
    e.bo = (ua < ub);
    return e;
  endfunction

  // mode 0: plain; mode 1: extra start issued mid-RUN; mode 2: reset at RUN cycle 3
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin,
                        input int mode, input int gap);
    a     = ta;
    b     = tb;
    bin   = tbin;
    start = 1'b1;
    if (mode != 2) begin
      q.push_back(model(ta, tb, tbin));
      n_pushed++;
    end
    @(posedge clk); #1;
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    bin   = 1'($urandom);
    if (mode == 1) begin
      repeat (2) @(posedge clk);
      #1;
      start = 1'b1;
      a     = 8'h10;
      b     = 8'h01;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (W - 3) @(posedge clk);
      #1;
    end else if (mode == 2) begin
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_valid", 32'(dout_valid), 0);
      check("rst_dout_bit", 32'(dout_bit), 0);
      check("rst_diff", 32'(diff), 0);
      check("rst_bout", 32'(bout), 0);
      repeat (2) @(negedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
    end else begin
      repeat (W) @(posedge clk);
      #1;
    end
    repeat (gap) @(posedge clk);
    if (gap > 0) #1;
  endtask

  // Monitor: collects serial bits and retires one scoreboard entry per done pulse.
  initial begin
    logic [W-1:0] got_bits;
    int           nbits;
    exp_t         last_e;
    exp_t         e;
    got_bits = '0;
    nbits    = 0;
    last_e   = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        nbits  = 0;
        last_e = '0;
        check("reset_outputs", {26'd0, busy, done, dout_valid, dout_bit, |diff, bout}, 0);
      end else begin
        check("busy_eq_valid", 32'(busy), 32'(dout_valid));
        if (dout_valid) begin
          if (nbits < W) got_bits[nbits] = dout_bit;
          nbits++;
        end
        if (done) begin
          n_done++;
          check("done_while_busy", 32'(busy), 0);
          if (q.size() == 0) begin
            check("unexpected_done", 1, 0);
          end else begin
            e = q.pop_front();
            check("diff", 32'(diff), 32'(e.d));
            check("bout", 32'(bout), 32'(e.bo));
            check("serial_bits", 32'(got_bits), 32'(e.d));
            check("run_cycles", nbits, W);
            last_e = e;
          end
          nbits = 0;
        end else if (!busy) begin
          check("held_diff", 32'(diff), 32'(last_e.d));
          check("held_bout", 32'(bout), 32'(last_e.bo));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    bin   = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(8'h05, 8'h03, 1'b0, 0, 1);
    run_op(8'h03, 8'h05, 1'b0, 0, 2);
    run_op(8'h00, 8'h00, 1'b1, 0, 1);
    run_op(8'hFF, 8'h01, 1'b0, 0, 1);
    run_op(8'h05, 8'h03, 1'b0, 1, 0);
    run_op(8'h80, 8'h01, 1'b0, 0, 2);
    run_op(8'h33, 8'h11, 1'b0, 2, 1);
    run_op(8'h0A, 8'h0A, 1'b0, 0, 1);
    run_op(8'h00, 8'hFF, 1'b1, 0, 0);
    run_op(8'hFF, 8'hFF, 1'b1, 0, 1);

    for (int i = 0; i < 40; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom),
             ($urandom_range(0, 4) == 0) ? 1 : 0, $urandom_range(0, 2));
    end

    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_empty", q.size(), 0);
    check("done_count", n_done, n_pushed);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
